// File: rtl/cache_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cache_set_ctrl
// Brief   : Single-set N-way write-back cache controller with age-based LRU.
// Revision: 1.0 - initial release
// ============================================================================
module cache_set_ctrl #(
    parameter int NUM_WAYS      = 4,
    parameter int COUNTER_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_write,
    output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);
    localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
    localparam int TAG_WIDTH    = ADDRESS_WIDTH - OFFSET_WIDTH;
    localparam int WAY_WIDTH    = $clog2(NUM_WAYS);
    localparam logic [COUNTER_WIDTH-1:0] C_AGE_MAX = COUNTER_WIDTH'(NUM_WAYS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        FILL_REQ  = 3'd3,
        FILL_WAIT = 3'd4,
        RESPOND   = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [TAG_WIDTH-1:0]     r_tag   [NUM_WAYS];
    logic [DATA_WIDTH-1:0]    r_data  [NUM_WAYS];
    logic [COUNTER_WIDTH-1:0] r_age   [NUM_WAYS];
    logic [NUM_WAYS-1:0]      r_valid;
    logic [NUM_WAYS-1:0]      r_dirty;
    logic                     r_write;
    logic                     r_hit;
    logic [TAG_WIDTH-1:0]     r_req_tag;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [WAY_WIDTH-1:0]     r_way;

    logic                     w_hit;
    logic [WAY_WIDTH-1:0]     w_hit_way;
    logic                     w_any_invalid;
    logic [WAY_WIDTH-1:0]     w_invalid_way;
    logic [WAY_WIDTH-1:0]     w_expired_way;
    logic [WAY_WIDTH-1:0]     w_victim;
    logic                     w_touch;
    logic [WAY_WIDTH-1:0]     w_touch_way;
    logic                     w_unused_offset;

    assign w_unused_offset = ^req_addr[OFFSET_WIDTH-1:0];

    // Descending scan so the lowest matching index wins each search.
    always_comb begin
        w_hit         = 1'b0;
        w_hit_way     = '0;
        w_any_invalid = 1'b0;
        w_invalid_way = '0;
        w_expired_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == r_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_WIDTH'(i);
            end
            if (!r_valid[i]) begin
                w_any_invalid = 1'b1;
                w_invalid_way = WAY_WIDTH'(i);
            end
            if (r_age[i] == C_AGE_MAX) begin
                w_expired_way = WAY_WIDTH'(i);
            end
        end
        w_victim = w_any_invalid ? w_invalid_way : w_expired_way;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (req_valid) w_state_next = LOOKUP;
            LOOKUP: begin
                if (w_hit)                                    w_state_next = RESPOND;
                else if (r_valid[w_victim] && r_dirty[w_victim]) w_state_next = WRITEBACK;
                else                                          w_state_next = FILL_REQ;
            end
            WRITEBACK: if (mem_req_ready)  w_state_next = FILL_REQ;
            FILL_REQ:  if (mem_req_ready)  w_state_next = FILL_WAIT;
            FILL_WAIT: if (mem_resp_valid) w_state_next = RESPOND;
            RESPOND:                       w_state_next = IDLE;
            default:                       w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    assign w_touch     = ((r_state == LOOKUP) && w_hit) || ((r_state == FILL_WAIT) && mem_resp_valid);
    assign w_touch_way = (r_state == LOOKUP) ? w_hit_way : r_way;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
                r_age[i]  <= COUNTER_WIDTH'(i);
            end
            r_valid   <= '0;
            r_dirty   <= '0;
            r_write   <= 1'b0;
            r_hit     <= 1'b0;
            r_req_tag <= '0;
            r_wdata   <= '0;
            r_way     <= '0;
        end else begin
            if ((r_state == IDLE) && req_valid) begin
                r_write   <= req_write;
                r_req_tag <= req_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
                r_wdata   <= req_wdata;
            end
            if (r_state == LOOKUP) begin
                r_hit <= w_hit;
                r_way <= w_hit ? w_hit_way : w_victim;
                if (w_hit && r_write) begin
                    r_data[w_hit_way]  <= r_wdata;
                    r_dirty[w_hit_way] <= 1'b1;
                end
            end
            if ((r_state == FILL_WAIT) && mem_resp_valid) begin
                r_tag[r_way]   <= r_req_tag;
                r_valid[r_way] <= 1'b1;
                r_dirty[r_way] <= r_write;
                r_data[r_way]  <= r_write ? r_wdata : mem_rdata;
            end
            // Ages younger than the touched way shift up by one; it becomes youngest.
            if (w_touch) begin
                for (int i = 0; i < NUM_WAYS; i++) begin
                    if (WAY_WIDTH'(i) == w_touch_way)
                        r_age[i] <= '0;
                    else if (r_age[i] < r_age[w_touch_way])
                        r_age[i] <= r_age[i] + COUNTER_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        req_ready     = (r_state == IDLE);
        resp_valid    = (r_state == RESPOND);
        resp_hit      = (r_state == RESPOND) && r_hit;
        resp_rdata    = (r_state == RESPOND) ? r_data[r_way] : '0;
        mem_req_valid = (r_state == WRITEBACK) || (r_state == FILL_REQ);
        mem_req_write = (r_state == WRITEBACK);
        mem_req_addr  = '0;
        mem_wdata     = '0;
        if (r_state == WRITEBACK) begin
            mem_req_addr = {r_tag[r_way], {OFFSET_WIDTH{1'b0}}};
            mem_wdata    = r_data[r_way];
        end else if (r_state == FILL_REQ) begin
            mem_req_addr = {r_req_tag, {OFFSET_WIDTH{1'b0}}};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_set_ctrl
// Brief   : Directed vector table plus random traffic against an LRU-queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cache_set_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_hit;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [31:0] mem_req_addr, mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    cache_set_ctrl #(
        .NUM_WAYS(4), .COUNTER_WIDTH(8), .DATA_WIDTH(32), .BLOCK_SIZE(32), .ADDRESS_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        hit;
        logic [31:0] rdata;
        logic        wb;
        logic [31:0] wb_addr;
        logic [31:0] wb_data;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        exp_t        e;
    } vec_t;

    typedef struct {
        logic        hit;
        logic [31:0] rdata;
        int          lat;
        logic        wb;
        logic [31:0] wb_addr;
        logic [31:0] wb_data;
        logic        fill;
        logic [31:0] fill_addr;
        logic        unstable;
        logic        timeout;
        logic        long_pulse;
    } obs_t;

    int n_checks = 0;
    int n_errors = 0;

    // Memory as seen by the DUT, and the memory the model believes in.
    logic [31:0] mem_dut [logic [26:0]];
    logic [31:0] mem_ref [logic [26:0]];

    // Model: per-way contents plus a recency list, most recently used first.
    logic        m_valid [4];
    logic        m_dirty [4];
    logic [26:0] m_tag   [4];
    logic [31:0] m_data  [4];
    int          m_order [$];

    function automatic logic [31:0] mem_default(input logic [26:0] t);
        return 32'hC0DE_0000 | {16'h0, t[15:0]};
    endfunction

    function automatic logic [31:0] dut_mem_rd(input logic [26:0] t);
        return mem_dut.exists(t) ? mem_dut[t] : mem_default(t);
    endfunction

    function automatic logic [31:0] ref_mem_rd(input logic [26:0] t);
        return mem_ref.exists(t) ? mem_ref[t] : mem_default(t);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
            m_data[i]  = '0;
        end
        m_order = {0, 1, 2, 3};
    endtask

    task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                output exp_t e);
        logic [26:0] t;
        int w;
        t = addr[31:5];
        w = -1;
        e = '{default: '0};
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && m_tag[i] == t) w = i;
        if (w >= 0) begin
            e.hit = 1'b1;
            if (wr) begin
                m_data[w]  = wdata;
                m_dirty[w] = 1'b1;
            end
        end else begin
            for (int i = 3; i >= 0; i--)
                if (!m_valid[i]) w = i;
            if (w < 0) w = m_order[$];
            if (m_valid[w] && m_dirty[w]) begin
                e.wb      = 1'b1;
                e.wb_addr = {m_tag[w], 5'b0};
                e.wb_data = m_data[w];
                mem_ref[m_tag[w]] = m_data[w];
            end
            m_valid[w] = 1'b1;
            m_tag[w]   = t;
            m_dirty[w] = wr;
            m_data[w]  = wr ? wdata : ref_mem_rd(t);
        end
        e.rdata = m_data[w];
        for (int k = 0; k < m_order.size(); k++)
            if (m_order[k] == w) begin
                m_order.delete(k);
                break;
            end
        m_order.push_front(w);
    endtask

    // Issues one request and plays the memory side until the response.
    task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input int dly, output obs_t o);
        int          cyc, hold, wait_cnt;
        logic        act, fill_pend, cap_wr;
        logic [31:0] cap_addr, cap_data;
        logic [26:0] fill_tag;
        cyc = 0; hold = 0; wait_cnt = 0;
        act = 1'b0; fill_pend = 1'b0; cap_wr = 1'b0;
        cap_addr = '0; cap_data = '0; fill_tag = '0;
        o = '{default: 0};
        o.timeout = 1'b1;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        for (int k = 0; k < 200; k++) begin
            cyc++;
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
            if (resp_valid) begin
                o.timeout = 1'b0;
                o.hit     = resp_hit;
                o.rdata   = resp_rdata;
                o.lat     = cyc;
                break;
            end
            if (fill_pend) begin
                if (wait_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = dut_mem_rd(fill_tag);
                    fill_pend      = 1'b0;
                end else wait_cnt--;
            end
            if (mem_req_valid) begin
                if (!act) begin
                    act = 1'b1; cap_wr = mem_req_write; cap_addr = mem_req_addr;
                    cap_data = mem_wdata; hold = dly;
                end else if (mem_req_write !== cap_wr || mem_req_addr !== cap_addr ||
                             mem_wdata !== cap_data) begin
                    o.unstable = 1'b1;
                end
                if (hold == 0) begin
                    mem_req_ready = 1'b1;
                    act = 1'b0;
                    if (cap_wr) begin
                        o.wb = 1'b1; o.wb_addr = cap_addr; o.wb_data = cap_data;
                        mem_dut[cap_addr[31:5]] = cap_data;
                    end else begin
                        o.fill = 1'b1; o.fill_addr = cap_addr;
                        fill_pend = 1'b1; fill_tag = cap_addr[31:5]; wait_cnt = dly;
                    end
                end else begin
                    hold--;
                    if (cap_wr && hold == 1) begin
                        mem_resp_valid = 1'b1;
                        mem_rdata      = 32'hBAD0_BAD0;
                    end
                end
            end
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        if (!o.timeout) begin
            @(posedge clk); #1;
            o.long_pulse = resp_valid;
        end
    endtask

    task automatic compare(input string nm, input logic [31:0] addr, input exp_t e, input obs_t o);
        check({nm, "_timeout"}, o.timeout, 0);
        check({nm, "_hit"}, o.hit, e.hit);
        check({nm, "_rdata"}, o.rdata, e.rdata);
        check({nm, "_wb"}, o.wb, e.wb);
        if (e.wb) begin
            check({nm, "_wb_addr"}, o.wb_addr, e.wb_addr);
            check({nm, "_wb_data"}, o.wb_data, e.wb_data);
        end
        check({nm, "_fill"}, o.fill, !e.hit);
        if (!e.hit) check({nm, "_fill_addr"}, o.fill_addr, {addr[31:5], 5'b0});
        else        check({nm, "_hit_latency"}, o.lat, 2);
        check({nm, "_mem_stable"}, o.unstable, 0);
        check({nm, "_resp_one_cycle"}, o.long_pulse, 0);
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input int dly, input logic hit, input logic [31:0] rdata,
                                input logic wb, input logic [31:0] wba, input logic [31:0] wbd);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.dly = dly;
        v.e.hit = hit; v.e.rdata = rdata; v.e.wb = wb; v.e.wb_addr = wba; v.e.wb_data = wbd;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs [14];
        exp_t  e;
        obs_t  o;
        logic  seen_fill;
        logic  any_resp;

        vecs[0]  = mk(0, 32'h0000_1040, 32'h0,         1, 0, 32'hDEAD_BEEF, 0, 32'h0, 32'h0);
        vecs[1]  = mk(0, 32'h0000_1040, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 32'h0, 32'h0);
        vecs[2]  = mk(1, 32'h0000_1044, 32'h1234_5678, 0, 1, 32'h1234_5678, 0, 32'h0, 32'h0);
        vecs[3]  = mk(0, 32'h0000_1048, 32'h0,         0, 1, 32'h1234_5678, 0, 32'h0, 32'h0);
        vecs[4]  = mk(0, 32'h0000_2000, 32'h0,         2, 0, 32'hC0DE_0100, 0, 32'h0, 32'h0);
        vecs[5]  = mk(0, 32'h0000_3000, 32'h0,         0, 0, 32'hC0DE_0180, 0, 32'h0, 32'h0);
        vecs[6]  = mk(0, 32'h0000_4000, 32'h0,         1, 0, 32'hC0DE_0200, 0, 32'h0, 32'h0);
        vecs[7]  = mk(1, 32'h0000_4004, 32'h4444_AAAA, 0, 1, 32'h4444_AAAA, 0, 32'h0, 32'h0);
        vecs[8]  = mk(0, 32'h0000_1040, 32'h0,         0, 1, 32'h1234_5678, 0, 32'h0, 32'h0);
        vecs[9]  = mk(0, 32'h0000_2010, 32'h0,         0, 1, 32'hC0DE_0100, 0, 32'h0, 32'h0);
        vecs[10] = mk(0, 32'h0000_3000, 32'h0,         0, 1, 32'hC0DE_0180, 0, 32'h0, 32'h0);
        vecs[11] = mk(0, 32'h0000_5000, 32'h0,         5, 0, 32'hC0DE_0280, 1, 32'h0000_4000, 32'h4444_AAAA);
        vecs[12] = mk(0, 32'h0000_4000, 32'h0,         1, 0, 32'h4444_AAAA, 1, 32'h0000_1040, 32'h1234_5678);
        vecs[13] = mk(1, 32'h0000_6000, 32'h6666_0001, 0, 0, 32'h6666_0001, 0, 32'h0, 32'h0);

        mem_dut[27'h82] = 32'hDEAD_BEEF;
        mem_ref[27'h82] = 32'hDEAD_BEEF;
        model_reset();

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_hit", resp_hit, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_mem_req_write", mem_req_write, 0);
        check("rst_mem_req_addr", mem_req_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            model_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, e);
            do_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].dly, o);
            compare($sformatf("vec%0d", i), vecs[i].addr, vecs[i].e, o);
        end

        for (int n = 0; n < 150; n++) begin
            logic        wr;
            logic [31:0] addr, wd;
            int          dly;
            wr   = 1'($urandom_range(0, 1));
            addr = 32'h0001_0000 | (32'($urandom_range(0, 7)) << 5) | (32'($urandom_range(0, 7)) << 2);
            wd   = $urandom;
            dly  = $urandom_range(0, 3);
            model_access(wr, addr, wd, e);
            do_access(wr, addr, wd, dly, o);
            compare($sformatf("rnd%0d", n), addr, e, o);
        end

        // Abort a miss while it waits for fill data.
        model_access(1'b0, 32'h0007_7000, 32'h0, e);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0007_7000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen_fill = 1'b0;
        for (int k = 0; k < 50; k++) begin
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                mem_req_ready = 1'b1;
                if (mem_req_write) mem_dut[mem_req_addr[31:5]] = mem_wdata;
                else               seen_fill = 1'b1;
            end
            @(posedge clk); #1;
            if (seen_fill) break;
        end
        mem_req_ready = 1'b0;
        check("abort_fill_issued", seen_fill, 1);
        check("abort_fill_wait_mem_idle", mem_req_valid, 0);
        rst = 1'b1;
        #1;
        check("abort_req_ready", req_ready, 1);
        check("abort_mem_req_valid", mem_req_valid, 0);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_mem_req_addr", mem_req_addr, 0);
        any_resp = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h5555_5555;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            any_resp = any_resp | resp_valid | mem_req_valid;
        end
        check("abort_quiet_in_reset", any_resp, 0);
        @(negedge clk);
        rst = 1'b0; mem_resp_valid = 1'b0;
        model_reset();

        for (int n = 0; n < 4; n++) begin
            logic [31:0] addr;
            addr = (n == 0) ? 32'h0007_7000 : (32'h0001_0000 | (32'(n) << 5));
            model_access(1'b0, addr, 32'h0, e);
            do_access(1'b0, addr, 32'h0, 0, o);
            compare($sformatf("post_rst%0d", n), addr, e, o);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
